// File: rtl/pe_pkg.sv
// Shared constants and FSM state type for the PE column controller.
package pe_pkg;

  localparam int unsigned O_CH   = 64;
  localparam int unsigned WIDTH  = 14;
  localparam int unsigned RD_LAT = 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StStream,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/valid_delay.sv
// One-bit shift register that tracks which activation slots carry valid data
// while they ripple down the PE column. DEPTH must be at least 2.
module valid_delay #(
  parameter int unsigned DEPTH = 64
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic din,
  output logic dout,
  output logic any
);

  logic [DEPTH-1:0] sr_q;

  // Shift valid bits one PE per cycle; reset flushes every slot.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[DEPTH-2:0], din};
    end
  end

  assign dout = sr_q[DEPTH-1];
  assign any  = |sr_q;

endmodule

// File: rtl/pe_column_ctrl.sv
// Control FSM for one systolic PE column: loads weights, streams activation
// reads, tracks result validity down the column and signals pass completion.
module pe_column_ctrl #(
  parameter int unsigned O_CH   = pe_pkg::O_CH,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = pe_pkg::RD_LAT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] num_act_in,
  input  logic              stall_in,
  output logic              w_load_out,
  output logic              act_rd_en_out,
  output logic [ADDR_W-1:0] act_addr_out,
  output logic              act_valid_out,
  output logic              psum_valid_out,
  output logic [ADDR_W-1:0] psum_idx_out,
  output logic              busy_out,
  output logic              done_out
);

  import pe_pkg::*;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] n_q;
  logic [ADDR_W-1:0] idx_q;
  logic [RD_LAT-1:0] rd_pipe_q;
  logic              rd_en;
  logic              act_valid;
  logic              psum_valid;
  logic              dl_any;
  logic              pipe_empty;

  // A stall suppresses the read in the same cycle, leaving a bubble.
  assign rd_en      = (state_q == StStream) && !stall_in;
  assign act_valid  = rd_pipe_q[RD_LAT-1];
  assign pipe_empty = !dl_any && (rd_pipe_q == '0);

  // Models the buffer read latency so act_valid lines up with returned data.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_pipe_q <= '0;
    end else begin
      rd_pipe_q[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
    end
  end

  valid_delay #(
    .DEPTH (O_CH)
  ) u_valid_delay (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .din    (act_valid),
    .dout   (psum_valid),
    .any    (dl_any)
  );

  // Pass sequencing plus address, N latch and result index counters.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      addr_q  <= '0;
      n_q     <= '0;
      idx_q   <= '0;
    end else begin
      if (psum_valid) begin
        idx_q <= idx_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            addr_q  <= '0;
            idx_q   <= '0;
            n_q     <= num_act_in;
            state_q <= (num_act_in == '0) ? StDone : StLoadW;
          end
        end
        StLoadW: begin
          state_q <= StStream;
        end
        StStream: begin
          if (!stall_in) begin
            addr_q <= addr_q + 1'b1;
            if (addr_q == n_q - 1'b1) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          // Wait until no valid slot remains in flight anywhere.
          if (pipe_empty) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign w_load_out     = (state_q == StLoadW);
  assign act_rd_en_out  = rd_en;
  assign act_addr_out   = addr_q;
  assign act_valid_out  = act_valid;
  assign psum_valid_out = psum_valid;
  assign psum_idx_out   = idx_q;
  assign busy_out       = (state_q != StIdle);
  assign done_out       = (state_q == StDone);

endmodule

// File: tb/tb_pe_column_ctrl.sv
// Directed bench for pe_column_ctrl with default parameters (64 PEs, 8-bit
// addresses, read latency 1). Cycle 0 of each pass is the cycle start is driven.
module tb_pe_column_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] num;
  logic       stall;
  logic       w_load;
  logic       rd_en;
  logic [7:0] addr;
  logic       act_valid;
  logic       psum_valid;
  logic [7:0] psum_idx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  int wl_c[$];
  int rd_c[$];
  int rd_a[$];
  int av_c[$];
  int pv_c[$];
  int pv_i[$];
  int dn_c[$];
  int busy_after_rst;

  always #5 clk = ~clk;

  pe_column_ctrl dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .start_in       (start),
    .num_act_in     (num),
    .stall_in       (stall),
    .w_load_out     (w_load),
    .act_rd_en_out  (rd_en),
    .act_addr_out   (addr),
    .act_valid_out  (act_valid),
    .psum_valid_out (psum_valid),
    .psum_idx_out   (psum_idx),
    .busy_out       (busy),
    .done_out       (done)
  );

  // Drives one pass and logs every output event by cycle number.
  task automatic run_pass(input int n, input int stall_from, input int stall_len,
                          input int restart_at, input int rst_at, input int max_cyc);
    int  tail;
    bit  fin;
    wl_c.delete(); rd_c.delete(); rd_a.delete(); av_c.delete();
    pv_c.delete(); pv_i.delete(); dn_c.delete();
    busy_after_rst = -1;
    tail = -1;
    fin  = 1'b0;
    for (int c = 0; c < max_cyc && !fin; c++) begin
      @(negedge clk);
      start = (c == 0) || (c == restart_at);
      num   = (c == 0) ? n[7:0] : 8'd7;
      stall = (c >= stall_from) && (c < stall_from + stall_len);
      rst   = (c == rst_at);
      #1;
      if (w_load) wl_c.push_back(c);
      if (rd_en) begin
        rd_c.push_back(c);
        rd_a.push_back(int'(addr));
      end
      if (act_valid) av_c.push_back(c);
      if (psum_valid) begin
        pv_c.push_back(c);
        pv_i.push_back(int'(psum_idx));
      end
      if (done) begin
        dn_c.push_back(c);
        tail = c;
      end
      if (c == rst_at + 1) busy_after_rst = int'(busy);
      if (tail >= 0 && c >= tail + 2) fin = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; stall = 1'b0; num = 8'd0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({w_load, rd_en, act_valid, psum_valid, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {w_load, rd_en, act_valid, psum_valid, busy, done});
    end
    checks++;
    if (addr !== 8'd0) begin
      errors++; $display("FAIL reset_addr got %0d want 0", addr);
    end
    checks++;
    if (psum_idx !== 8'd0) begin
      errors++; $display("FAIL reset_idx got %0d want 0", psum_idx);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_pass(4, 1000, 0, -1, -1, 200);
    checks++;
    if (wl_c.size() !== 1 || (wl_c.size() == 1 && wl_c[0] !== 1)) begin
      errors++; $display("FAIL basic_wload got %0d pulses want 1 at cycle 1", wl_c.size());
    end
    checks++;
    if (rd_c.size() !== 4) begin
      errors++; $display("FAIL basic_rd_count got %0d want 4", rd_c.size());
    end
    for (int i = 0; i < rd_c.size() && i < 4; i++) begin
      checks++;
      if (rd_c[i] !== 2 + i || rd_a[i] !== i) begin
        errors++;
        $display("FAIL basic_rd[%0d] got cyc %0d addr %0d want cyc %0d addr %0d",
                 i, rd_c[i], rd_a[i], 2 + i, i);
      end
    end
    for (int i = 0; i < av_c.size() && i < 4; i++) begin
      checks++;
      if (av_c[i] !== 3 + i) begin
        errors++; $display("FAIL basic_act_valid[%0d] got %0d want %0d", i, av_c[i], 3 + i);
      end
    end
    checks++;
    if (pv_c.size() !== 4) begin
      errors++; $display("FAIL basic_pv_count got %0d want 4", pv_c.size());
    end
    for (int i = 0; i < pv_c.size() && i < 4; i++) begin
      checks++;
      if (pv_c[i] !== 67 + i || pv_i[i] !== i) begin
        errors++;
        $display("FAIL basic_pv[%0d] got cyc %0d idx %0d want cyc %0d idx %0d",
                 i, pv_c[i], pv_i[i], 67 + i, i);
      end
    end
    checks++;
    if (dn_c.size() !== 1 || (dn_c.size() == 1 && (dn_c[0] <= 70 || dn_c[0] > 73))) begin
      errors++; $display("FAIL basic_done got %0d pulses want 1 in cycles 71..73", dn_c.size());
    end
  endtask

  task automatic test_stall();
    run_pass(3, 3, 2, -1, -1, 200);
    checks++;
    if (rd_c.size() !== 3) begin
      errors++; $display("FAIL stall_rd_count got %0d want 3", rd_c.size());
    end
    if (rd_c.size() == 3) begin
      checks++;
      if (rd_c[0] !== 2 || rd_c[1] !== 5 || rd_c[2] !== 6 || rd_a[2] !== 2) begin
        errors++;
        $display("FAIL stall_rd got cyc %0d %0d %0d last addr %0d want 2 5 6 addr 2",
                 rd_c[0], rd_c[1], rd_c[2], rd_a[2]);
      end
    end
    checks++;
    if (pv_c.size() !== 3) begin
      errors++; $display("FAIL stall_pv_count got %0d want 3", pv_c.size());
    end
    if (pv_c.size() == 3) begin
      checks++;
      if (pv_c[0] !== 67 || pv_c[1] !== 70 || pv_c[2] !== 71) begin
        errors++;
        $display("FAIL stall_pv_pattern got %0d %0d %0d want 67 70 71", pv_c[0], pv_c[1], pv_c[2]);
      end
      checks++;
      if (pv_i[0] !== 0 || pv_i[1] !== 1 || pv_i[2] !== 2) begin
        errors++;
        $display("FAIL stall_idx got %0d %0d %0d want 0 1 2", pv_i[0], pv_i[1], pv_i[2]);
      end
    end
    checks++;
    if (dn_c.size() !== 1) begin
      errors++; $display("FAIL stall_done got %0d want 1", dn_c.size());
    end
  endtask

  task automatic test_zero();
    run_pass(0, 1000, 0, -1, -1, 20);
    checks++;
    if (wl_c.size() !== 0 || rd_c.size() !== 0) begin
      errors++;
      $display("FAIL zero_activity got wload %0d reads %0d want 0 0", wl_c.size(), rd_c.size());
    end
    checks++;
    if (dn_c.size() !== 1 || (dn_c.size() == 1 && dn_c[0] > 2)) begin
      errors++; $display("FAIL zero_done got %0d pulses want 1 within 2 cycles", dn_c.size());
    end
  endtask

  task automatic test_abort();
    run_pass(4, 1000, 0, -1, 30, 120);
    checks++;
    if (busy_after_rst !== 0) begin
      errors++; $display("FAIL abort_idle got busy %0d want 0", busy_after_rst);
    end
    checks++;
    if (pv_c.size() !== 0) begin
      errors++; $display("FAIL abort_pv got %0d valids want 0", pv_c.size());
    end
    checks++;
    if (dn_c.size() !== 0) begin
      errors++; $display("FAIL abort_done got %0d pulses want 0", dn_c.size());
    end
  endtask

  task automatic test_restart();
    run_pass(4, 1000, 0, 3, -1, 200);
    checks++;
    if (rd_c.size() !== 4 || pv_c.size() !== 4) begin
      errors++;
      $display("FAIL restart_counts got reads %0d valids %0d want 4 4", rd_c.size(), pv_c.size());
    end
    checks++;
    if (dn_c.size() !== 1) begin
      errors++; $display("FAIL restart_done got %0d want 1", dn_c.size());
    end
  endtask

  task automatic test_max();
    int bad;
    run_pass(255, 1000, 0, -1, -1, 400);
    checks++;
    if (rd_c.size() !== 255) begin
      errors++; $display("FAIL max_rd_count got %0d want 255", rd_c.size());
    end
    bad = 0;
    for (int i = 0; i < rd_a.size(); i++) if (rd_a[i] !== i) bad++;
    checks++;
    if (bad !== 0 || rd_a.size() == 0 || rd_a[rd_a.size()-1] !== 254) begin
      errors++; $display("FAIL max_addr_seq got %0d out of order want 0, last 254", bad);
    end
    checks++;
    if (pv_c.size() !== 255) begin
      errors++; $display("FAIL max_pv_count got %0d want 255", pv_c.size());
    end
    checks++;
    if (pv_i.size() == 0 || pv_i[pv_i.size()-1] !== 254 || pv_c[0] !== 67) begin
      errors++; $display("FAIL max_idx_end got size %0d want last idx 254 first cyc 67", pv_i.size());
    end
    checks++;
    if (dn_c.size() !== 1) begin
      errors++; $display("FAIL max_done got %0d want 1", dn_c.size());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; num = 8'd0;
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_abort();
    test_restart();
    test_max();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
